// File: rtl/yin_tau_scheduler_pkg.sv
// Shared definitions for the YIN lag scheduler and its difference datapath:
// FSM encoding plus the common tau, address and accumulator widths.
package yin_tau_scheduler_pkg;

  localparam int YIN_ADDR_W    = 16;
  localparam int YIN_TAU_W     = 6;
  localparam int YIN_ACC_WIDTH = 39;
  localparam int YIN_MAX_TAU   = 40;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } yin_state_t;

endpackage

// File: rtl/yin_min_tracker.sv
// Running minimum of d(tau) over a sweep. Keeps a backup of the previous
// sweep's result so an aborted sweep can hand the old result back.
module yin_min_tracker
  import yin_tau_scheduler_pkg::*;
#(
  parameter int TAU_W     = YIN_TAU_W,
  parameter int ACC_WIDTH = YIN_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 init_i,
  input  logic [TAU_W-1:0]     init_tau_i,
  input  logic                 capture_i,
  input  logic                 restore_i,
  input  logic [TAU_W-1:0]     tau_i,
  input  logic [ACC_WIDTH-1:0] value_i,
  output logic [TAU_W-1:0]     best_tau_o,
  output logic [ACC_WIDTH-1:0] best_value_o
);

  logic [TAU_W-1:0]     best_tau_q, best_tau_d;
  logic [ACC_WIDTH-1:0] best_value_q, best_value_d;
  logic [TAU_W-1:0]     bak_tau_q, bak_tau_d;
  logic [ACC_WIDTH-1:0] bak_value_q, bak_value_d;

  // Init snapshots and clears, capture loads on a strictly smaller value
  // (so ties keep the earlier, smaller lag), restore returns the snapshot.
  always_comb begin
    best_tau_d   = best_tau_q;
    best_value_d = best_value_q;
    bak_tau_d    = bak_tau_q;
    bak_value_d  = bak_value_q;
    if (init_i) begin
      bak_tau_d    = best_tau_q;
      bak_value_d  = best_value_q;
      best_tau_d   = init_tau_i;
      best_value_d = '1;
    end else if (restore_i) begin
      best_tau_d   = bak_tau_q;
      best_value_d = bak_value_q;
    end else if (capture_i && (value_i < best_value_q)) begin
      best_tau_d   = tau_i;
      best_value_d = value_i;
    end
  end

  // Result and backup registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      best_tau_q   <= '0;
      best_value_q <= '0;
      bak_tau_q    <= '0;
      bak_value_q  <= '0;
    end else begin
      best_tau_q   <= best_tau_d;
      best_value_q <= best_value_d;
      bak_tau_q    <= bak_tau_d;
      bak_value_q  <= bak_value_d;
    end
  end

  assign best_tau_o   = best_tau_q;
  assign best_value_o = best_value_q;

endmodule

// File: rtl/yin_tau_scheduler.sv
// Sweeps tau from TAU_MIN to MAX_TAU over the difference datapath, tracking
// the lag with minimum d(tau). Each lag: ARM (clear datapath), RUN (wait for
// diff_ready, first cycle ignored as possibly stale), CAPTURE (compare).
// Handshake: diff_ready is a level from the datapath, cleared only by
// diff_reset; it is qualified once per lag and no back-pressure exists.
module yin_tau_scheduler
  import yin_tau_scheduler_pkg::*;
#(
  parameter int TAU_MIN        = 1,
  parameter int MAX_TAU        = YIN_MAX_TAU,
  parameter int ACC_WIDTH      = YIN_ACC_WIDTH,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [YIN_ADDR_W-1:0] frame_address,
  output logic [YIN_ADDR_W-1:0] diff_initial_address,
  output logic [YIN_TAU_W-1:0]  diff_tau,
  output logic                  diff_reset,
  input  logic                  diff_ready,
  input  logic [ACC_WIDTH-1:0]  diff_accumulator,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [YIN_TAU_W-1:0]  best_tau,
  output logic [ACC_WIDTH-1:0]  best_value,
  output yin_state_t            dbg_state
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_SAT  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [YIN_TAU_W-1:0] TAU_FIRST = YIN_TAU_W'(TAU_MIN);
  localparam logic [YIN_TAU_W-1:0] TAU_LAST  = YIN_TAU_W'(MAX_TAU);

  yin_state_t            state_q, state_d;
  logic [YIN_ADDR_W-1:0] addr_q, addr_d;
  logic [YIN_TAU_W-1:0]  tau_q, tau_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  error_q, error_d;
  logic                  err_bak_q, err_bak_d;
  logic                  trk_init, trk_capture, trk_restore;

  // Next-state and control decode; abort beats ready and timeout.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tau_d       = tau_q;
    to_cnt_d    = to_cnt_q;
    error_d     = error_q;
    err_bak_d   = err_bak_q;
    trk_init    = 1'b0;
    trk_capture = 1'b0;
    trk_restore = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d    = frame_address;
          tau_d     = TAU_FIRST;
          err_bak_d = error_q;
          error_d   = 1'b0;
          trk_init  = 1'b1;
          state_d   = ST_ARM;
        end
      end
      ST_ARM: begin
        to_cnt_d = '0;
        if (abort) begin
          trk_restore = 1'b1;
          error_d     = err_bak_q;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          trk_restore = 1'b1;
          error_d     = err_bak_q;
          state_d     = ST_IDLE;
        end else begin
          if (to_cnt_q != TO_SAT) to_cnt_d = to_cnt_q + 1'b1;
          // A zero count marks the first RUN cycle, where ready may be stale.
          if (diff_ready && (to_cnt_q != '0)) begin
            state_d = ST_CAPTURE;
          end else if (to_cnt_q >= TO_LAST) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          trk_restore = 1'b1;
          error_d     = err_bak_q;
          state_d     = ST_IDLE;
        end else begin
          trk_capture = 1'b1;
          if (tau_q == TAU_LAST) begin
            state_d = ST_DONE;
          end else begin
            tau_d   = tau_q + 1'b1;
            state_d = ST_ARM;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched address/lag, timeout counter and error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      tau_q     <= '0;
      to_cnt_q  <= '0;
      error_q   <= 1'b0;
      err_bak_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tau_q     <= tau_d;
      to_cnt_q  <= to_cnt_d;
      error_q   <= error_d;
      err_bak_q <= err_bak_d;
    end
  end

  yin_min_tracker #(
    .TAU_W     (YIN_TAU_W),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_min_tracker (
    .clk          (clk),
    .reset_n      (reset_n),
    .init_i       (trk_init),
    .init_tau_i   (TAU_FIRST),
    .capture_i    (trk_capture),
    .restore_i    (trk_restore),
    .tau_i        (tau_q),
    .value_i      (diff_accumulator),
    .best_tau_o   (best_tau),
    .best_value_o (best_value)
  );

  // The datapath is held cleared while reset is asserted as well as in ARM.
  assign diff_reset           = (state_q == ST_ARM) || !reset_n;
  assign busy                 = (state_q == ST_ARM) || (state_q == ST_RUN) ||
                                (state_q == ST_CAPTURE);
  assign done                 = (state_q == ST_DONE);
  assign error                = error_q;
  assign diff_tau             = tau_q;
  assign diff_initial_address = addr_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_yin_tau_scheduler.sv
// Directed bench for yin_tau_scheduler with a behavioural difference
// datapath: ready L cycles after clear, d(tau) taken from a table.
module tb_yin_tau_scheduler;
  import yin_tau_scheduler_pkg::*;

  localparam int L      = 10;
  localparam int NLAGS  = 40;
  localparam int LAG_CY = L + 3;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  start;
  logic                  abort;
  logic [15:0]           frame_address;
  logic [15:0]           diff_initial_address;
  logic [5:0]            diff_tau;
  logic                  diff_reset;
  logic                  diff_ready;
  logic [38:0]           diff_accumulator;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [5:0]            best_tau;
  logic [38:0]           best_value;
  yin_state_t            dbg_state;

  // Clock / reset block
  always #5 clk = ~clk;

  yin_tau_scheduler #(
    .TAU_MIN        (1),
    .MAX_TAU        (40),
    .ACC_WIDTH      (39),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .start                (start),
    .abort                (abort),
    .frame_address        (frame_address),
    .diff_initial_address (diff_initial_address),
    .diff_tau             (diff_tau),
    .diff_reset           (diff_reset),
    .diff_ready           (diff_ready),
    .diff_accumulator     (diff_accumulator),
    .busy                 (busy),
    .done                 (done),
    .error                (error),
    .best_tau             (best_tau),
    .best_value           (best_value),
    .dbg_state            (dbg_state)
  );

  // Behavioural datapath
  logic [38:0] dtab [0:63];
  logic [7:0]  dp_cnt;
  logic        dp_stale;
  logic        stale_mode;
  logic        never_en;
  logic [5:0]  never_tau;

  always @(posedge clk) begin
    if (diff_reset) begin
      // Stale mode keeps ready high one extra cycle past the clear.
      dp_stale <= stale_mode && (dp_cnt == 8'(L));
      dp_cnt   <= '0;
    end else begin
      dp_stale <= 1'b0;
      if (dp_cnt < 8'(L)) dp_cnt <= dp_cnt + 8'd1;
    end
  end

  assign diff_ready = ((dp_cnt == 8'(L)) || dp_stale) &&
                      !(never_en && (diff_tau == never_tau));
  assign diff_accumulator = dtab[diff_tau];

  // Scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;
  int cyc;
  bit done_seen;
  int done_at;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic step();
    @(negedge clk);
    cyc++;
    if (done === 1'b1 && !done_seen) begin
      done_seen = 1'b1;
      done_at   = cyc;
    end
  endtask

  // Pulse start for one cycle; on return cyc=1 is the ARM cycle of TAU_MIN.
  task automatic launch(input logic [15:0] addr, input bit with_abort);
    frame_address = addr;
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start     = 1'b0;
    abort     = 1'b0;
    cyc       = 1;
    done_seen = 1'b0;
    done_at   = 0;
  endtask

  task automatic finish_sweep();
    while (!done_seen && cyc < 3000) step();
  endtask

  task automatic set_vee();
    for (int i = 0; i < 64; i++)
      dtab[i] = 39'(50 + 10 * ((i > 17) ? (i - 17) : (17 - i)));
  endtask

  task automatic set_tie();
    for (int i = 0; i < 64; i++) dtab[i] = 39'd100;
    dtab[5] = 39'd7;
    dtab[9] = 39'd7;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; frame_address = '0;
    stale_mode = 1'b0; never_en = 1'b0; never_tau = '0;
    cyc = 0; done_seen = 1'b0; done_at = 0;
    set_vee();

    // Reset state
    #3;
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_diff_reset", 64'(diff_reset), 64'd1);
    check("rst_best_value", 64'(best_value), 64'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_diff_reset", 64'(diff_reset), 64'd0);

    // V-shaped table: minimum 50 at tau 17. Each lag takes L+3 cycles; with
    // ARM of lag 1 as cycle 1, done falls in cycle 40*13+1 (522 counting the
    // start cycle).
    launch(16'h1234, 1'b0);
    check("arm_state", 64'(dbg_state), 64'(ST_ARM));
    check("arm_diff_reset", 64'(diff_reset), 64'd1);
    check("arm_tau", 64'(diff_tau), 64'd1);
    check("arm_addr", 64'(diff_initial_address), 64'h1234);
    check("arm_busy", 64'(busy), 64'd1);
    step();
    check("run_state", 64'(dbg_state), 64'(ST_RUN));
    check("run_diff_reset", 64'(diff_reset), 64'd0);
    frame_address = 16'hFFFF;
    step();
    check("run_addr_stable", 64'(diff_initial_address), 64'h1234);
    finish_sweep();
    check("vee_done_seen", 64'(done_seen), 64'd1);
    check("vee_done_cycle", 64'(done_at), 64'(NLAGS * LAG_CY + 1));
    check("vee_best_tau", 64'(best_tau), 64'd17);
    check("vee_best_value", 64'(best_value), 64'd50);
    check("vee_error", 64'(error), 64'd0);
    check("vee_done_busy", 64'(busy), 64'd0);
    step();
    check("vee_done_pulse", 64'(done), 64'd0);
    check("vee_idle", 64'(dbg_state), 64'(ST_IDLE));

    // Tie: d(5)=d(9)=7; start and abort together in IDLE, start wins.
    set_tie();
    launch(16'hBEEF, 1'b1);
    check("tie_start_wins", 64'(dbg_state), 64'(ST_ARM));
    finish_sweep();
    check("tie_done_seen", 64'(done_seen), 64'd1);
    check("tie_best_tau", 64'(best_tau), 64'd5);
    check("tie_best_value", 64'(best_value), 64'd7);
    step();

    // Abort during RUN of tau 20: prior result 5/7 must come back.
    launch(16'h0100, 1'b0);
    while (!(dbg_state == ST_RUN && diff_tau == 6'd20) && cyc < 1000) step();
    check("abort_reached", 64'(diff_tau), 64'd20);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    step(); step();
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_best_tau", 64'(best_tau), 64'd5);
    check("abort_best_value", 64'(best_value), 64'd7);
    check("abort_error", 64'(error), 64'd0);
    launch(16'h0200, 1'b0);
    check("resweep_tau", 64'(diff_tau), 64'd1);
    finish_sweep();
    check("resweep_done_cycle", 64'(done_at), 64'(NLAGS * LAG_CY + 1));
    check("resweep_best_tau", 64'(best_tau), 64'd5);
    step();

    // Stale ready held past the clear, plus a start re-pulse at tau 10.
    set_vee();
    stale_mode = 1'b1;
    launch(16'h0300, 1'b0);
    while (diff_tau != 6'd10 && cyc < 1000) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("repulse_busy", 64'(busy), 64'd1);
    check("repulse_tau", 64'(diff_tau), 64'd10);
    finish_sweep();
    check("stale_done_cycle", 64'(done_at), 64'(NLAGS * LAG_CY + 1));
    check("stale_best_tau", 64'(best_tau), 64'd17);
    check("stale_best_value", 64'(best_value), 64'd50);
    stale_mode = 1'b0;
    step();

    // Datapath never readies at tau 3; timeout after 64 RUN cycles.
    never_en  = 1'b1;
    never_tau = 6'd3;
    launch(16'h0400, 1'b0);
    finish_sweep();
    check("to_done_cycle", 64'(done_at), 64'(2 * LAG_CY + 1 + 64 + 1));
    check("to_error", 64'(error), 64'd1);
    check("to_diff_tau", 64'(diff_tau), 64'd3);
    check("to_best_tau", 64'(best_tau), 64'd2);
    check("to_best_value", 64'(best_value), 64'd200);
    step(); step();
    check("to_error_hold", 64'(error), 64'd1);
    never_en = 1'b0;

    // Reset mid-RUN: outputs go to reset values without waiting for a clock.
    launch(16'h0500, 1'b0);
    check("new_start_clears_error", 64'(error), 64'd0);
    for (int i = 0; i < 5; i++) step();
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_diff_reset", 64'(diff_reset), 64'd1);
    check("mid_rst_tau", 64'(diff_tau), 64'd0);
    check("mid_rst_addr", 64'(diff_initial_address), 64'd0);
    check("mid_rst_best_tau", 64'(best_tau), 64'd0);
    check("mid_rst_best_value", 64'(best_value), 64'd0);
    check("mid_rst_error", 64'(error), 64'd0);
    step(); step();
    reset_n = 1'b1;
    step(); step(); step();
    check("post_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_diff_reset", 64'(diff_reset), 64'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
